// File: rtl/pc_redirect_ctrl_if.sv
// Redirect/halt signal bundle between the pipeline's redirect sources and pc_redirect_ctrl.
// The master side drives requests; the slave side is the controller.
interface pc_redirect_ctrl_if;
  logic        trap_req_i;
  logic [31:0] trap_vec_i;
  logic        br_req_i;
  logic [31:0] br_target_i;
  logic        jal_req_i;
  logic [31:0] jal_target_i;
  logic        stall_i;
  logic        halt_req_i;
  logic        resume_i;
  logic        isTakenBranch_o;
  logic [31:0] targetPC_o;
  logic        halt_o;
  logic        flush_o;
  logic        misalign_o;
  logic [31:0] misalign_addr_o;
  logic [15:0] redirect_cnt_o;

  modport master (
    output trap_req_i, trap_vec_i, br_req_i, br_target_i, jal_req_i, jal_target_i,
           stall_i, halt_req_i, resume_i,
    input  isTakenBranch_o, targetPC_o, halt_o, flush_o, misalign_o,
           misalign_addr_o, redirect_cnt_o
  );

  modport slave (
    input  trap_req_i, trap_vec_i, br_req_i, br_target_i, jal_req_i, jal_target_i,
           stall_i, halt_req_i, resume_i,
    output isTakenBranch_o, targetPC_o, halt_o, flush_o, misalign_o,
           misalign_addr_o, redirect_cnt_o
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// RV32I PC redirect sequencer: fixed-priority redirect arbitration, alignment check,
// boot hold, post-redirect flush window and halt/resume control.
module pc_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned BOOT_CYCLES  = 4
) (
  input logic               clk_i,
  input logic               reset_ni,
  pc_redirect_ctrl_if.slave bus
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned RCNT_W = 16;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_taken;
  logic [XLEN-1:0]   r_target;
  logic              r_flush;
  logic              r_misalign;
  logic [XLEN-1:0]   r_mis_addr;
  logic [RCNT_W-1:0] r_redir_cnt;

  state_e            w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_accept;
  logic [XLEN-1:0]   w_target_nxt;
  logic              w_misalign_nxt;
  logic [XLEN-1:0]   w_mis_addr_nxt;
  logic [XLEN-1:0]   w_cand;

  // Next-state, counter and registered-output decode
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_accept       = 1'b0;
    w_target_nxt   = r_target;
    w_misalign_nxt = 1'b0;
    w_mis_addr_nxt = r_mis_addr;
    w_cand         = bus.br_req_i ? bus.br_target_i : bus.jal_target_i;

    unique case (r_state)
      ST_BOOT: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (bus.trap_req_i) begin
          w_accept     = 1'b1;
          w_target_nxt = bus.trap_vec_i;
        end else if (bus.br_req_i || bus.jal_req_i) begin
          // Only the winning br/jal target is alignment-checked; losers are dropped
          if (w_cand[1:0] != 2'b00) begin
            w_misalign_nxt = 1'b1;
            w_mis_addr_nxt = w_cand;
            w_state_nxt    = ST_HALTED;
          end else begin
            w_accept     = 1'b1;
            w_target_nxt = w_cand;
          end
        end else if (bus.halt_req_i) begin
          w_state_nxt = ST_HALTED;
        end
      end
      ST_FLUSH: begin
        if (bus.trap_req_i) begin
          w_accept     = 1'b1;
          w_target_nxt = bus.trap_vec_i;
        end else if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      ST_HALTED: begin
        if (bus.trap_req_i) begin
          w_accept     = 1'b1;
          w_target_nxt = bus.trap_vec_i;
        end else if (bus.resume_i) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_BOOT;
    endcase

    // Any accepted redirect (re)opens the flush window
    if (w_accept) begin
      w_state_nxt = ST_FLUSH;
      w_cnt_nxt   = CNT_W'(FLUSH_CYCLES);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state     <= ST_BOOT;
      r_cnt       <= CNT_W'(BOOT_CYCLES);
      r_taken     <= 1'b0;
      r_target    <= '0;
      r_flush     <= 1'b0;
      r_misalign  <= 1'b0;
      r_mis_addr  <= '0;
      r_redir_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_taken     <= w_accept;
      r_target    <= w_target_nxt;
      r_flush     <= (w_state_nxt == ST_FLUSH);
      r_misalign  <= w_misalign_nxt;
      r_mis_addr  <= w_mis_addr_nxt;
      r_redir_cnt <= r_redir_cnt + RCNT_W'(w_accept);
    end
  end

  assign bus.isTakenBranch_o = r_taken;
  assign bus.targetPC_o      = r_target;
  assign bus.flush_o         = r_flush;
  assign bus.misalign_o      = r_misalign;
  assign bus.misalign_addr_o = r_mis_addr;
  assign bus.redirect_cnt_o  = r_redir_cnt;
  // Intentional combinational stall path into the PC hold
  assign bus.halt_o = (r_state == ST_BOOT) || (r_state == ST_HALTED) || bus.stall_i;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: directed stimulus pushes expected strobes,
// a negedge monitor pops and compares them; a small PC model checks advance/freeze.
module tb_pc_redirect_ctrl;

  typedef struct {
    bit          mis;
    logic [31:0] addr;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] pc;
  logic [31:0] p;
  int n_chk = 0;
  int n_pass = 0;
  exp_t q[$];
  exp_t e;

  pc_redirect_ctrl_if bus ();

  pc_redirect_ctrl #(.FLUSH_CYCLES(2), .BOOT_CYCLES(4)) dut (
    .clk_i   (clk),
    .reset_ni(rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference PC register driven by the controller outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= 32'h120;
    else if (bus.isTakenBranch_o) pc <= bus.targetPC_o;
    else if (!bus.halt_o) pc <= pc + 32'd4;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.trap_req_i = 1'b0;
    bus.br_req_i   = 1'b0;
    bus.jal_req_i  = 1'b0;
    bus.halt_req_i = 1'b0;
    bus.resume_i   = 1'b0;
  endtask

  task automatic push(input bit mis, input logic [31:0] addr, input logic [15:0] cnt);
    exp_t x;
    x.mis = mis; x.addr = addr; x.cnt = cnt;
    q.push_back(x);
  endtask

  // Monitor: every strobe or misalign pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (bus.isTakenBranch_o || bus.misalign_o) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected: taken=%b misalign=%b target=%h at %0t",
                 bus.isTakenBranch_o, bus.misalign_o, bus.targetPC_o, $time);
      end else begin
        e = q.pop_front();
        chk("sb_taken", 32'(bus.isTakenBranch_o), 32'(!e.mis));
        chk("sb_misalign", 32'(bus.misalign_o), 32'(e.mis));
        chk("sb_addr", bus.isTakenBranch_o ? bus.targetPC_o : bus.misalign_addr_o, e.addr);
        chk("sb_cnt", 32'(bus.redirect_cnt_o), 32'(e.cnt));
      end
    end
  end

  initial begin
    clr();
    bus.stall_i      = 1'b0;
    bus.trap_vec_i   = '0;
    bus.br_target_i  = '0;
    bus.jal_target_i = '0;
    cyc(); cyc();
    chk("rst_halt", 32'(bus.halt_o), 32'd1);
    chk("rst_taken", 32'(bus.isTakenBranch_o), 32'd0);
    chk("rst_target", bus.targetPC_o, 32'h0);
    chk("rst_flush", 32'(bus.flush_o), 32'd0);
    chk("rst_misalign", 32'(bus.misalign_o), 32'd0);
    chk("rst_cnt", 32'(bus.redirect_cnt_o), 32'd0);

    // Boot hold, with a branch request that must be ignored
    rst_n = 1'b1;
    bus.br_req_i = 1'b1; bus.br_target_i = 32'h600;
    cyc(); cyc(); cyc();
    clr();
    chk("boot_halt3", 32'(bus.halt_o), 32'd1);
    cyc();
    chk("boot_halt4", 32'(bus.halt_o), 32'd0);
    chk("boot_pc0", pc, 32'h120);
    cyc();
    chk("boot_pc1", pc, 32'h124);

    // Arbitration br vs jal
    bus.br_req_i = 1'b1;  bus.br_target_i  = 32'h200;
    bus.jal_req_i = 1'b1; bus.jal_target_i = 32'h300;
    push(1'b0, 32'h200, 16'd1);
    cyc(); clr();
    chk("arb_flush1", 32'(bus.flush_o), 32'd1);
    cyc();
    chk("arb_flush2", 32'(bus.flush_o), 32'd1);
    chk("arb_pc", pc, 32'h200);
    cyc();
    chk("arb_flush3", 32'(bus.flush_o), 32'd0);

    // Flush filtering and trap restart
    bus.br_req_i = 1'b1; bus.br_target_i = 32'h400;
    push(1'b0, 32'h400, 16'd2);
    cyc();
    bus.br_target_i = 32'h500;
    cyc(); clr();
    chk("ff_flush2", 32'(bus.flush_o), 32'd1);
    bus.trap_req_i = 1'b1; bus.trap_vec_i = 32'h80;
    push(1'b0, 32'h80, 16'd3);
    cyc(); clr();
    chk("ff_restart1", 32'(bus.flush_o), 32'd1);
    cyc();
    chk("ff_restart2", 32'(bus.flush_o), 32'd1);
    cyc();
    chk("ff_end", 32'(bus.flush_o), 32'd0);

    // Trap vectors bypass the alignment check
    bus.trap_req_i = 1'b1; bus.trap_vec_i = 32'h82;
    push(1'b0, 32'h82, 16'd4);
    cyc(); clr(); cyc(); cyc();

    // Misaligned branch winner: dropped, pulse, halt
    bus.br_req_i = 1'b1;  bus.br_target_i  = 32'h202;
    bus.jal_req_i = 1'b1; bus.jal_target_i = 32'h300;
    push(1'b1, 32'h202, 16'd4);
    cyc(); clr();
    chk("mis_halt", 32'(bus.halt_o), 32'd1);
    chk("mis_addr", bus.misalign_addr_o, 32'h202);
    p = pc;
    bus.jal_req_i = 1'b1; bus.jal_target_i = 32'h700;
    cyc(); clr();
    chk("mis_pulse_end", 32'(bus.misalign_o), 32'd0);
    chk("mis_halt_hold", 32'(bus.halt_o), 32'd1);
    cyc();
    chk("halted_pc_frozen", pc, p);
    chk("mis_addr_hold", bus.misalign_addr_o, 32'h202);

    // Resume
    bus.resume_i = 1'b1;
    cyc(); clr();
    chk("resume_halt", 32'(bus.halt_o), 32'd0);
    p = pc;
    cyc();
    chk("resume_pc", pc, p + 32'd4);

    // Halt request loses to a same-cycle redirect
    bus.halt_req_i = 1'b1; bus.jal_req_i = 1'b1; bus.jal_target_i = 32'h900;
    push(1'b0, 32'h900, 16'd5);
    cyc(); clr();
    chk("hr_redir_halt", 32'(bus.halt_o), 32'd0);
    chk("hr_redir_flush", 32'(bus.flush_o), 32'd1);
    cyc(); cyc();
    chk("hr_run_halt", 32'(bus.halt_o), 32'd0);

    // Halt request alone, then trap out of HALTED
    bus.halt_req_i = 1'b1;
    cyc(); clr();
    chk("hr_halted", 32'(bus.halt_o), 32'd1);
    bus.trap_req_i = 1'b1; bus.trap_vec_i = 32'h40;
    push(1'b0, 32'h40, 16'd6);
    cyc(); clr();
    chk("htrap_halt", 32'(bus.halt_o), 32'd0);
    chk("htrap_flush", 32'(bus.flush_o), 32'd1);
    cyc(); cyc();

    // Stall drives halt combinationally but never blocks a redirect
    bus.stall_i = 1'b1;
    #1;
    chk("stall_halt", 32'(bus.halt_o), 32'd1);
    bus.br_req_i = 1'b1; bus.br_target_i = 32'hA00;
    push(1'b0, 32'hA00, 16'd7);
    cyc(); clr();
    chk("stall_flush", 32'(bus.flush_o), 32'd1);
    cyc();
    chk("stall_pc", pc, 32'hA00);
    bus.stall_i = 1'b0;
    cyc();

    // Reset mid-flush
    bus.br_req_i = 1'b1; bus.br_target_i = 32'hB00;
    push(1'b0, 32'hB00, 16'd8);
    cyc(); clr(); cyc();
    chk("mf_flush_pre", 32'(bus.flush_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mf_flush", 32'(bus.flush_o), 32'd0);
    chk("mf_cnt", 32'(bus.redirect_cnt_o), 32'd0);
    chk("mf_halt", 32'(bus.halt_o), 32'd1);
    chk("mf_target", bus.targetPC_o, 32'h0);
    chk("mf_mis_addr", bus.misalign_addr_o, 32'h0);
    chk("mf_taken", 32'(bus.isTakenBranch_o), 32'd0);
    cyc();
    rst_n = 1'b1;
    repeat (4) cyc();
    chk("reboot_halt", 32'(bus.halt_o), 32'd0);
    cyc();
    chk("sb_drain", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Sequencing controller for the RV32I program-counter register. It sits between the pipeline's redirect sources (trap unit, execute-stage branch, decode-stage jump), the stall/halt logic, and the PC register. It arbitrates simultaneous redirects by fixed priority, checks target alignment, and drives the PC's taken/target/halt inputs. It also sequences the boot hold, post-redirect flush windows and halt/resume.

## Interface
- FLUSH_CYCLES, 2: cycles `flush_o` stays high per accepted redirect, including the redirect cycle (legal 1..15).
- BOOT_CYCLES, 4: cycles PC is held halted after reset release (legal 1..15).
- clk_i  in  1  clock, all state on rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- trap_req_i  in  1  trap/exception redirect request (highest priority).
- trap_vec_i  in  32  trap vector target.
- br_req_i  in  1  execute-stage taken branch/JALR.
- br_target_i  in  32  branch target.
- jal_req_i  in  1  decode-stage JAL (lowest priority).
- jal_target_i  in  32  JAL target.
- stall_i  in  1  pipeline stall; freezes sequential PC advance.
- halt_req_i  in  1  ECALL/EBREAK halt request.
- resume_i  in  1  leave HALTED.
- isTakenBranch_o  out  1  one-cycle redirect strobe to PC.
- targetPC_o  out  32  redirect target to PC; valid while `isTakenBranch_o` is high.
- halt_o  out  1  halt to PC.
- flush_o  out  1  squash wrong-path instructions in the fetch/decode stages.
- misalign_o  out  1  one-cycle pulse: dropped redirect had `target[1:0] != 0`.
- misalign_addr_o  out  32  offending target; holds until the next misalign.
- redirect_cnt_o  out  16  count of accepted redirects; wraps at 0xFFFF→0.

## Operation
- **States:**
  - BOOT: entered on reset. A 4-bit down-counter is loaded with BOOT_CYCLES. At 0 the controller goes to RUN. Redirects are ignored in BOOT.
  - RUN: normal operation.
  - FLUSH: counter runs; go to RUN at count 0.
  - HALTED: held until `resume_i` or a trap.
- **Arbitration (RUN):** trap > br > jal; exactly one redirect is accepted per cycle and the losers are dropped.
- **Eligibility in FLUSH:** only trap is eligible. br and jal are wrong-path and are ignored.
- **Eligibility in HALTED:** only trap is eligible.
- **Alignment:** if the winning br or jal target has `[1:0] != 0`:
  - no redirect is issued;
  - `misalign_o` pulses and `misalign_addr_o` is loaded;
  - next state is HALTED.
  - Trap vectors are not checked.
- **Accepted redirect:**
  - `isTakenBranch_o` = 1 and `targetPC_o` = target for one cycle;
  - `flush_o` counter is loaded with FLUSH_CYCLES and the state goes to FLUSH;
  - `redirect_cnt_o` increments.
  - A trap during FLUSH reloads the counter.
- **Halt:** `halt_req_i` in RUN with no accepted redirect moves to HALTED. A same-cycle redirect wins and the halt request is dropped.
- **Resume:** `resume_i` in HALTED moves to RUN next cycle. A trap in HALTED goes to FLUSH and issues the redirect.
- **Halt output:** `halt_o` = (state ∈ {BOOT, HALTED}) | `stall_i`. This is the only combinational input→output path.
- **Stall:** `stall_i` never blocks redirects; the PC register accepts a taken redirect while halted.

## Timing
- **Reset values** (asynchronous on `reset_ni` = 0):
  - state = BOOT;
  - `isTakenBranch_o` = 0, `targetPC_o` = 0, `flush_o` = 0, `misalign_o` = 0;
  - `misalign_addr_o` = 0, `redirect_cnt_o` = 0;
  - `halt_o` = 1.
- **Boot hold:** `halt_o` stays 1 for exactly BOOT_CYCLES rising edges after `reset_ni` rises, plus any `stall_i`.
- **Redirect latency:** a request sampled at edge N gives registered `isTakenBranch_o`/`targetPC_o` high between edges N and N+1. The PC loads the target at edge N+1.
- **Flush window:** `flush_o` is high for exactly FLUSH_CYCLES cycles, starting in the same cycle as the strobe.
- **Misalign timing:** `misalign_o` is high one cycle after the offending request. `halt_o` is 1 from that cycle onward.
- **Reset mid-flush or mid-halt:** everything aborts immediately to reset values; no redirect is emitted.
- **Counter wrap:** `redirect_cnt_o` wraps silently at 0xFFFF→0.

## Test plan
- **Boot:** release reset with BOOT_CYCLES=4 → `halt_o` = 1 for 4 cycles then 0; the PC advances 0x120→0x124.
- **Arbitration:** `br_req_i` (target 0x200) and `jal_req_i` (target 0x300) in the same cycle → one strobe with `targetPC_o` = 0x200; `flush_o` high 2 cycles; `redirect_cnt_o` = 1.
- **Flush filtering:** a branch to 0x400 accepted, then a br to 0x500 during FLUSH → ignored. A trap to 0x80 during FLUSH → strobe to 0x80 and the flush window restarts (2 more cycles).
- **Misalign:** `br_target_i` = 0x202 → no strobe; `misalign_o` pulses; `misalign_addr_o` = 0x202; `halt_o` = 1 until `resume_i`.
- **Halt/resume:** `halt_req_i` in RUN → HALTED and the PC is frozen. `resume_i` → RUN and the PC advances by 4 per cycle. A trap in HALTED → strobe and FLUSH.
- **Reset mid-flush:** assert `reset_ni` = 0 during FLUSH → all outputs reach reset values immediately and `redirect_cnt_o` = 0.
